serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Serial bit-stream receiver that consumes a one-bit output stream `y`, as produced by the design's serial sequence generator. It hunts for a fixed sync pattern, captures the following DATA_W bits as a data word, and reports each completed frame. It is the receive end of the serial link: it turns the generator's bit sequence back into words and frame events for downstream logic.

## Interface
- `SYNC_W`, 4: sync pattern length in bits (≥2).
- `SYNC_PAT`, 4'b1011: sync pattern, MSB is the first bit on the wire.
- `DATA_W`, 8: payload bits per frame (≥1), MSB first.
- `CNT_W`, 8: width of the frame counter.
- `clk`  in  1: single clock, all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `y_valid`  in  1: qualifies `y`; a bit is consumed only on a rising edge where `y_valid`=1.
- `y`  in  1: serial data bit.
- `sync_det`  out  1: one-cycle pulse when the sync pattern completes.
- `busy`  out  1: high while in CAPTURE.
- `data`  out  DATA_W: last completed payload word; held until the next frame completes.
- `data_valid`  out  1: one-cycle pulse when `data` updates.
- `frame_cnt`  out  CNT_W: completed-frame count, saturates at 2^CNT_W−1.

## Operation
- State machine with two states: HUNT (reset state) and CAPTURE. `busy` = (state==CAPTURE), registered.
- HUNT:
  - Keep a SYNC_W-bit history shift register and a fill counter that saturates at SYNC_W. Both are cleared on reset and on frame completion.
  - On each consumed bit: history ← {history[SYNC_W-2:0], y}; fill increments.
  - Match rule: fill ≥ SYNC_W−1 before the shift, and {history[SYNC_W-2:0], y} == SYNC_PAT. Bits left in the history from reset or from a prior frame can never create a match.
  - Search is overlapping: every consumed bit is a candidate end of pattern. Example: stream 1,0,1,0,1,1 matches on the 6th bit.
  - On a match: pulse `sync_det`, go to CAPTURE, clear the data bit counter.
- CAPTURE:
  - Each consumed bit shifts into a capture shift register, MSB first. The sync search is disabled, so payload bits that contain SYNC_PAT do not assert `sync_det`.
  - On the DATA_W-th consumed bit:
    - `data` ← {capture[DATA_W-2:0], y};
    - pulse `data_valid`;
    - `frame_cnt` ← min(frame_cnt+1, 2^CNT_W−1);
    - clear history and fill;
    - return to HUNT.
- Cycles with `y_valid`=0 hold all state. The pulses still fall after one cycle.
- Bit counter width is clog2(DATA_W+1). Arithmetic is unsigned, with no wrap on `frame_cnt`.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=HUNT;
  - `sync_det`=0, `busy`=0, `data`=0, `data_valid`=0, `frame_cnt`=0;
  - history, fill, capture and bit counter = 0.
- Reset asserted mid-frame takes effect immediately and discards the partial frame. The first bit is consumed at the first rising edge with `reset`=1.
- All outputs are registered.
- If the last sync bit is consumed at edge k:
  - `sync_det`=1 and `busy`=1 during the cycle after edge k;
  - `sync_det` returns to 0 at edge k+1;
  - the first payload bit can be consumed at edge k+1.
- If the last payload bit is consumed at edge m:
  - `data`, `data_valid`=1, the incremented `frame_cnt` and `busy`=0 are all visible after edge m;
  - `data_valid` returns to 0 at edge m+1.
- Back-to-back frames: the first sync bit of the next frame can be consumed at edge m+1, with no dead cycle.
- Minimum frame is SYNC_W+DATA_W consumed bits. With `y_valid` held at 1, `data_valid` follows the first sync bit by SYNC_W+DATA_W−1 edges.

## Test plan
- Reset: drive `reset`=0 mid-stream. Required: all outputs 0 immediately, with no clock edge needed. After release with `y`=0 and `y_valid`=1 for 20 cycles: no pulses.
- Basic frame (defaults, `y_valid`=1): drive 1011 then 10100101. Required: `sync_det` pulses after the 4th bit; `data_valid` pulses after the 12th bit with `data`=8'hA5; `frame_cnt`=1; `busy` high for exactly 8 cycles.
- Overlap and payload immunity: drive 101011 then 10110000. Required: `sync_det` pulses once, on the 6th bit. Then `data`=8'hB0, with no second `sync_det` during the payload.
- Valid gaps: repeat the basic frame with `y_valid`=0 for 3 cycles between every bit. Required: `data`=8'hA5 and `frame_cnt`=1; each pulse is exactly one cycle, timed from the bit that completes it.
- Reset mid-capture: drive sync plus 5 payload bits, then pulse `reset`=0. Required: `busy`=0 and `frame_cnt`=0. Then 1011 followed by 0x3C gives `data`=8'h3C and `frame_cnt`=1.
- Saturation and back-to-back: set `CNT_W`=2 and send 5 consecutive frames with no gaps. Required: `frame_cnt` reads 1,2,3,3,3, and all 5 `data_valid` pulses occur.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
// Receive end of the serial link. Hunts the one-bit stream for SYNC_PAT,
// captures the next DATA_W bits MSB first as a word, and reports each
// completed frame with a data_valid pulse and a saturating frame counter.

module serial_frame_receiver #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                DATA_W   = 8,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              y_valid,
    input  logic              y,
    output logic              sync_det,
    output logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    // Fill level at which the history plus the incoming bit form a whole pattern
    localparam logic [FILL_W-1:0] FILL_MATCH = FILL_W'(SYNC_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(SYNC_W);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [SYNC_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              sync_det_q, sync_det_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic [SYNC_W-1:0] hist_shift;
    logic [DATA_W-1:0] cap_shift;
    logic              sync_match;

    // Candidate history/capture values if the current bit is consumed
    always_comb begin
        hist_shift = {hist_q[SYNC_W-2:0], y};
        cap_shift  = (cap_q << 1) | DATA_W'(y);
        sync_match = (fill_q >= FILL_MATCH) && (hist_shift == SYNC_PAT);
    end

    // Next-state logic: HUNT searches for the pattern, CAPTURE assembles the word
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        cap_d        = cap_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        frame_cnt_d  = frame_cnt_q;
        data_valid_d = 1'b0;
        sync_det_d   = 1'b0;

        if (y_valid) begin
            if (state_q == ST_HUNT) begin
                hist_d = hist_shift;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if (sync_match) begin
                    sync_det_d = 1'b1;
                    state_d    = ST_CAPTURE;
                    bit_cnt_d  = '0;
                end
            end else begin
                cap_d     = cap_shift;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    data_d       = cap_shift;
                    data_valid_d = 1'b1;
                    if (frame_cnt_q != CNT_MAX) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                    // Stale bits from this frame must never help form the next sync
                    hist_d    = '0;
                    fill_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_HUNT;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            hist_q       <= '0;
            fill_q       <= '0;
            cap_q        <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sync_det_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            cap_q        <= cap_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sync_det_q   <= sync_det_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign sync_det   = sync_det_q;
    assign busy       = (state_q == ST_CAPTURE);
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
// Directed bench for serial_frame_receiver. Two instances share the stimulus:
// the default configuration and one with a 2-bit frame counter to exercise
// saturation. Expected values are hand-computed from the bit patterns.

module tb_serial_frame_receiver;

    logic       clk;
    logic       reset;
    logic       y_valid;
    logic       y;

    logic       sync_det;
    logic       busy;
    logic [7:0] data;
    logic       data_valid;
    logic [7:0] frame_cnt;

    logic       sat_sync_det;
    logic       sat_busy;
    logic [7:0] sat_data;
    logic       sat_data_valid;
    logic [1:0] sat_frame_cnt;

    int total = 0;
    int bad   = 0;

    // Pulse bookkeeping filled in by applyStimulus on every sampled cycle
    int syncCount;
    int syncPos;
    int dvCount;
    int dvPos;
    int busyCount;
    int satDvCount;

    serial_frame_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .y_valid    (y_valid),
        .y          (y),
        .sync_det   (sync_det),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .frame_cnt  (frame_cnt)
    );

    serial_frame_receiver #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .y_valid    (y_valid),
        .y          (y),
        .sync_det   (sat_sync_det),
        .busy       (sat_busy),
        .data       (sat_data),
        .data_valid (sat_data_valid),
        .frame_cnt  (sat_frame_cnt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point: counts it and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record pulses and busy for the cycle just sampled; pos is the bit index or 0 for a gap
    task automatic sampleOutputs(input int pos);
        if (sync_det === 1'b1) begin
            syncCount++;
            if (pos != 0) syncPos = pos;
        end
        if (data_valid === 1'b1) begin
            dvCount++;
            if (pos != 0) dvPos = pos;
        end
        if (busy === 1'b1) busyCount++;
        if (sat_data_valid === 1'b1) satDvCount++;
    endtask

    // Shift n bits (MSB first) into the receiver, with gap idle cycles after each bit
    task automatic applyStimulus(input logic [31:0] bits, input int n, input int gap);
        syncCount  = 0;
        syncPos    = -1;
        dvCount    = 0;
        dvPos      = -1;
        busyCount  = 0;
        satDvCount = 0;
        for (int i = 0; i < n; i++) begin
            y       = bits[n-1-i];
            y_valid = 1'b1;
            @(posedge clk);
            #1;
            sampleOutputs(i + 1);
            for (int g = 0; g < gap; g++) begin
                y_valid = 1'b0;
                y       = ~y;
                @(posedge clk);
                #1;
                sampleOutputs(0);
            end
        end
    endtask

    // Assert reset between clock edges, check the immediate effect, release after an edge
    task automatic pulseReset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        checkOutput({tag, "_outs"}, {22'd0, sync_det, busy, data, data_valid}, 32'd0);
        checkOutput({tag, "_cnt"}, {24'd0, frame_cnt}, 32'd0);
        checkOutput({tag, "_satcnt"}, {30'd0, sat_frame_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] satPayload [5];
    int         satExpect  [5];

    // Linear directed sequence
    initial begin
        reset   = 1'b1;
        y_valid = 1'b0;
        y       = 1'b0;
        satPayload = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'hB6};
        satExpect  = '{1, 2, 3, 3, 3};

        // Power-on reset
        pulseReset("por");

        // Basic frame: sync 1011 then payload A5
        applyStimulus({20'd0, 4'b1011, 8'hA5}, 12, 0);
        checkOutput("basic_sync_cnt", syncCount, 1);
        checkOutput("basic_sync_pos", syncPos, 4);
        checkOutput("basic_dv_cnt", dvCount, 1);
        checkOutput("basic_dv_pos", dvPos, 12);
        checkOutput("basic_busy_cycles", busyCount, 8);
        checkOutput("basic_data", {24'd0, data}, 32'hA5);
        checkOutput("basic_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        checkOutput("basic_busy_end", {31'd0, busy}, 32'd0);
        applyStimulus(32'd0, 1, 0);
        checkOutput("basic_dv_fall", dvCount, 0);
        checkOutput("basic_data_hold", {24'd0, data}, 32'hA5);

        // Reset mid-stream clears held data and the counter at once
        applyStimulus(32'b10, 2, 0);
        pulseReset("mid_stream");

        // Idle zeros after reset produce no pulses
        applyStimulus(32'd0, 20, 0);
        checkOutput("zeros_sync", syncCount, 0);
        checkOutput("zeros_dv", dvCount, 0);
        checkOutput("zeros_busy", busyCount, 0);

        // Overlapping sync search and payload immunity
        applyStimulus({18'd0, 6'b101011, 8'hB0}, 14, 0);
        checkOutput("overlap_sync_cnt", syncCount, 1);
        checkOutput("overlap_sync_pos", syncPos, 6);
        checkOutput("overlap_dv_pos", dvPos, 14);
        checkOutput("overlap_data", {24'd0, data}, 32'hB0);
        checkOutput("overlap_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        // Basic frame with three invalid cycles after every bit
        pulseReset("gap_pre");
        applyStimulus({20'd0, 4'b1011, 8'hA5}, 12, 3);
        checkOutput("gap_sync_cnt", syncCount, 1);
        checkOutput("gap_sync_pos", syncPos, 4);
        checkOutput("gap_dv_cnt", dvCount, 1);
        checkOutput("gap_dv_pos", dvPos, 12);
        checkOutput("gap_busy_cycles", busyCount, 32);
        checkOutput("gap_data", {24'd0, data}, 32'hA5);
        checkOutput("gap_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        // Reset in the middle of a capture drops the partial frame
        applyStimulus({23'd0, 4'b1011, 5'b10101}, 9, 0);
        checkOutput("midcap_busy_before", {31'd0, busy}, 32'd1);
        pulseReset("midcap");
        applyStimulus({20'd0, 4'b1011, 8'h3C}, 12, 0);
        checkOutput("midcap_dv_pos", dvPos, 12);
        checkOutput("midcap_data", {24'd0, data}, 32'h3C);
        checkOutput("midcap_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        // Five back-to-back frames; the 2-bit counter saturates at 3
        pulseReset("sat_pre");
        for (int k = 0; k < 5; k++) begin
            applyStimulus({20'd0, 4'b1011, satPayload[k]}, 12, 0);
            checkOutput($sformatf("b2b_dv_pos_%0d", k), dvPos, 12);
            checkOutput($sformatf("b2b_sync_pos_%0d", k), syncPos, 4);
            checkOutput($sformatf("b2b_data_%0d", k), {24'd0, data}, {24'd0, satPayload[k]});
            checkOutput($sformatf("b2b_cnt_%0d", k), {24'd0, frame_cnt}, k + 1);
            checkOutput($sformatf("sat_dv_%0d", k), satDvCount, 1);
            checkOutput($sformatf("sat_cnt_%0d", k), {30'd0, sat_frame_cnt}, satExpect[k]);
        end
        y_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
